// File: rtl/gshare_predictor.sv
// gshare direction predictor: PC xor speculative global history indexes a table of
// saturating counters. Optional write-through forwarding under `GSHARE_FWD_EN.
module gshare_predictor #(
  parameter int INDEX_BITS = 8,
  parameter int HIST_BITS  = 8,
  parameter int CTR_BITS   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          pc_f_i,
  input  logic                 predict_en_i,
  output logic                 predict_taken_o,
  output logic [HIST_BITS-1:0] predict_hist_o,
  output logic                 ready_o,
  input  logic                 update_en_i,
  input  logic [31:0]          update_pc_i,
  input  logic [HIST_BITS-1:0] update_hist_i,
  input  logic                 update_taken_i,
  input  logic                 update_mispredict_i
);
  localparam int DEPTH = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS-1)) - 1);

  if (HIST_BITS < 1 || HIST_BITS > INDEX_BITS) begin : g_bad_hist
    $fatal(1, "gshare_predictor: HIST_BITS must be in 1..INDEX_BITS");
  end
  if (CTR_BITS < 1 || CTR_BITS > 4) begin : g_bad_ctr
    $fatal(1, "gshare_predictor: CTR_BITS must be in 1..4");
  end

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e                state_q, state_d;
  logic [INDEX_BITS-1:0] init_ptr_q, init_ptr_d;
  logic [HIST_BITS-1:0]  spec_hist_q, spec_hist_d;
  logic [CTR_BITS-1:0]   ctr_q [DEPTH];

  logic [INDEX_BITS-1:0] fidx, uidx, wr_idx;
  logic [CTR_BITS-1:0]   ctr_f, ctr_u, ctr_u_nxt, wr_val;
  logic                  upd_act, wr_en, pred_raw;

  assign fidx    = pc_f_i[INDEX_BITS+1:2] ^ INDEX_BITS'(spec_hist_q);
  assign uidx    = update_pc_i[INDEX_BITS+1:2] ^ INDEX_BITS'(update_hist_i);
  assign ctr_f   = ctr_q[fidx];
  assign ctr_u   = ctr_q[uidx];
  assign upd_act = (state_q == S_RUN) && update_en_i;

  logic unused_pc;
  assign unused_pc = ^{pc_f_i[31:INDEX_BITS+2], pc_f_i[1:0],
                       update_pc_i[31:INDEX_BITS+2], update_pc_i[1:0]};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      init_ptr_q  <= '0;
      spec_hist_q <= '0;
    end else begin
      state_q     <= state_d;
      init_ptr_q  <= init_ptr_d;
      spec_hist_q <= spec_hist_d;
    end
  end

  // Next state: sweep every entry once, then run
  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    if (state_q == S_INIT) begin
      init_ptr_d = init_ptr_q + INDEX_BITS'(1);
      if (init_ptr_q == '1) state_d = S_RUN;
    end
  end

  always_comb begin
    ctr_u_nxt = ctr_u;
    if (update_taken_i) begin
      if (ctr_u != CTR_MAX) ctr_u_nxt = ctr_u + CTR_BITS'(1);
    end else begin
      if (ctr_u != '0) ctr_u_nxt = ctr_u - CTR_BITS'(1);
    end
  end

  always_comb begin
    wr_en  = rst_n && ((state_q == S_INIT) || upd_act);
    wr_idx = (state_q == S_INIT) ? init_ptr_q : uidx;
    wr_val = (state_q == S_INIT) ? CTR_INIT : ctr_u_nxt;
  end

  // Table is not reset; the INIT sweep establishes its contents
  always_ff @(posedge clk) begin
    if (wr_en) ctr_q[wr_idx] <= wr_val;
  end

`ifdef GSHARE_FWD_EN
  assign pred_raw = (upd_act && (fidx == uidx)) ? ctr_u_nxt[CTR_BITS-1] : ctr_f[CTR_BITS-1];
`else
  assign pred_raw = ctr_f[CTR_BITS-1];
`endif

  // Outputs
  always_comb begin
    ready_o         = (state_q == S_RUN);
    predict_taken_o = (state_q == S_RUN) && pred_raw;
    predict_hist_o  = (state_q == S_RUN) ? spec_hist_q : '0;
  end

  // Mispredict repair wins over the speculative shift of a same-cycle prediction
  always_comb begin
    spec_hist_d = spec_hist_q;
    if (state_q == S_RUN) begin
      if (update_en_i && update_mispredict_i)
        spec_hist_d = HIST_BITS'({update_hist_i, update_taken_i});
      else if (predict_en_i)
        spec_hist_d = HIST_BITS'({spec_hist_q, predict_taken_o});
    end
  end
endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor (INDEX_BITS=HIST_BITS=4, CTR_BITS=2) with a
// per-cycle reference model and hand-computed expectations.
module tb_gshare_predictor;
  localparam int IB = 4, HB = 4, CB = 2;
  localparam int DEPTH = 1 << IB, CMAX = (1 << CB) - 1, CINIT = (1 << (CB-1)) - 1;
  localparam int HMASK = (1 << HB) - 1;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [31:0]   pc_f_i = '0, update_pc_i = '0;
  logic          predict_en_i = 1'b0, update_en_i = 1'b0;
  logic          update_taken_i = 1'b0, update_mispredict_i = 1'b0;
  logic [HB-1:0] update_hist_i = '0;
  logic          predict_taken_o, ready_o;
  logic [HB-1:0] predict_hist_o;

  gshare_predictor #(.INDEX_BITS(IB), .HIST_BITS(HB), .CTR_BITS(CB)) dut (
    .clk(clk), .rst_n(rst_n), .pc_f_i(pc_f_i), .predict_en_i(predict_en_i),
    .predict_taken_o(predict_taken_o), .predict_hist_o(predict_hist_o), .ready_o(ready_o),
    .update_en_i(update_en_i), .update_pc_i(update_pc_i), .update_hist_i(update_hist_i),
    .update_taken_i(update_taken_i), .update_mispredict_i(update_mispredict_i));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: table as plain ints, init as a countdown
  int m_ctr [DEPTH];
  int m_hist = 0, m_left = 0, m_u = 0;
  bit m_valid = 1'b0, m_p = 1'b0;

  function automatic int m_fidx();
    return (int'(pc_f_i >> 2) ^ m_hist) & (DEPTH-1);
  endfunction
  function automatic int m_uidx();
    return (int'(update_pc_i >> 2) ^ int'(update_hist_i)) & (DEPTH-1);
  endfunction
  function automatic int m_next(int c, bit t);
    if (t) return (c < CMAX) ? c + 1 : c;
    return (c > 0) ? c - 1 : c;
  endfunction
  function automatic bit m_pred();
    int c;
    if (m_left != 0) return 1'b0;
    c = m_ctr[m_fidx()];
`ifdef GSHARE_FWD_EN
    if (update_en_i && m_uidx() == m_fidx()) c = m_next(c, update_taken_i);
`endif
    return c >= (1 << (CB-1));
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid = 1'b1; m_left = DEPTH; m_hist = 0;
    end else if (m_valid && m_left > 0) begin
      m_left--;
      if (m_left == 0) foreach (m_ctr[i]) m_ctr[i] = CINIT;
    end else if (m_valid) begin
      m_p = m_pred();
      m_u = m_uidx();
      if (update_en_i) m_ctr[m_u] = m_next(m_ctr[m_u], update_taken_i);
      if (update_en_i && update_mispredict_i)
        m_hist = ((int'(update_hist_i) << 1) | int'(update_taken_i)) & HMASK;
      else if (predict_en_i)
        m_hist = ((m_hist << 1) | int'(m_p)) & HMASK;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("mdl_ready", int'(ready_o), int'(m_left == 0));
      chk("mdl_pred", int'(predict_taken_o), int'(m_pred()));
      chk("mdl_hist", int'(predict_hist_o), (m_left == 0) ? m_hist : 0);
    end
  end

  task automatic drive(bit pen, logic [31:0] pc, bit uen, logic [31:0] upc,
                       logic [HB-1:0] uh, bit ut, bit um);
    @(posedge clk); #1;
    predict_en_i = pen; pc_f_i = pc; update_en_i = uen; update_pc_i = upc;
    update_hist_i = uh; update_taken_i = ut; update_mispredict_i = um;
    @(negedge clk);
  endtask

  task automatic idle(logic [31:0] pc);
    drive(1'b0, pc, 1'b0, 32'h0, '0, 1'b0, 1'b0);
  endtask

  task automatic count_init(string name);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk); chk(name, int'(ready_o), 0);
    end
    @(negedge clk); chk({name, "_done"}, int'(ready_o), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_ready", int'(ready_o), 0);
    chk("rst_hist", int'(predict_hist_o), 0);
    @(posedge clk); #1; rst_n = 1'b1;
    count_init("init_ready");

    for (int i = 0; i < DEPTH; i++) begin
      idle(32'(i << 2)); chk("entry_init", int'(predict_taken_o), 0);
    end

    // Restart the sweep partway through
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); chk("sweep_pre", int'(ready_o), 0);
    end
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    count_init("sweep_restart");

    // Saturation at entry 0 (PC 0x40, hist 0)
    for (int k = 0; k < 3; k++) drive(0, 32'h3C, 1, 32'h40, 4'h0, 1, 0);
    idle(32'h40); chk("sat_hi", int'(predict_taken_o), 1);
    drive(0, 32'h3C, 1, 32'h40, 4'h0, 0, 0);
    idle(32'h40); chk("dec_from_max", int'(predict_taken_o), 1);
    for (int k = 0; k < 3; k++) drive(0, 32'h3C, 1, 32'h40, 4'h0, 0, 0);
    idle(32'h40); chk("sat_lo", int'(predict_taken_o), 0);
    drive(0, 32'h3C, 1, 32'h40, 4'h0, 1, 0);
    idle(32'h40); chk("inc_from_0", int'(predict_taken_o), 0);
    drive(0, 32'h3C, 1, 32'h40, 4'h0, 1, 0);
    idle(32'h40); chk("inc_to_2", int'(predict_taken_o), 1);

    // Speculative history: predictions 1,0,1 -> 4'b0101
    drive(0, 32'h3C, 1, 32'h0C, 4'h0, 1, 0);
    drive(0, 32'h3C, 1, 32'h0C, 4'h0, 1, 0);
    drive(1, 32'h0C, 0, 32'h0, 4'h0, 0, 0); chk("spec_p1", int'(predict_taken_o), 1);
    drive(1, 32'h00, 0, 32'h0, 4'h0, 0, 0); chk("spec_p2", int'(predict_taken_o), 0);
    chk("spec_h1", int'(predict_hist_o), 1);
    drive(1, 32'h04, 0, 32'h0, 4'h0, 0, 0); chk("spec_p3", int'(predict_taken_o), 1);
    chk("spec_h2", int'(predict_hist_o), 2);
    idle(32'h40); chk("spec_hist", int'(predict_hist_o), 5);
    chk("idx5_before", int'(predict_taken_o), 0);
    drive(0, 32'h3C, 1, 32'h40, 4'h5, 1, 0);
    drive(0, 32'h3C, 1, 32'h40, 4'h5, 1, 0);
    idle(32'h40); chk("idx5_after", int'(predict_taken_o), 1);

    // Recovery overrides a same-cycle predict shift
    drive(0, 32'h3C, 1, 32'h3C, 4'h7, 1, 1);
    drive(1, 32'h3C, 1, 32'h3C, 4'h2, 1, 1); chk("recov_1111", int'(predict_hist_o), 15);
    idle(32'h3C); chk("recov_0101", int'(predict_hist_o), 5);
    drive(0, 32'h3C, 1, 32'h3C, 4'h0, 1, 0);
    idle(32'h3C); chk("no_mis_hold", int'(predict_hist_o), 5);

    // Aliasing: A=0x10/hist 0 and B=0x14/hist 1 share index 4
    drive(0, 32'h3C, 1, 32'h3C, 4'h0, 0, 1);
    drive(0, 32'h3C, 1, 32'h10, 4'h0, 1, 0);
    drive(0, 32'h3C, 1, 32'h10, 4'h0, 1, 0);
    idle(32'h10); chk("alias_a", int'(predict_taken_o), 1);
    chk("alias_a_hist", int'(predict_hist_o), 0);
    drive(0, 32'h3C, 1, 32'h3C, 4'h0, 1, 1);
    idle(32'h14); chk("alias_b_hist", int'(predict_hist_o), 1);
    chk("alias_b", int'(predict_taken_o), 1);

    // Same-cycle read/update on index 7 (counter 01, taken)
    drive(0, 32'h18, 1, 32'h1C, 4'h0, 1, 0);
`ifdef GSHARE_FWD_EN
    chk("same_cycle", int'(predict_taken_o), 1);
`else
    chk("same_cycle", int'(predict_taken_o), 0);
`endif
    idle(32'h18); chk("same_next", int'(predict_taken_o), 1);

    idle(32'h0); idle(32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
- Parametrised successor of the 2-bit fetch-stage branch history table.
- Pattern table is indexed by PC XOR a speculative global history register (gshare).
- Counter width, table depth and history length are configurable.
- Adds a post-reset table-initialisation sweep, mispredict-driven history recovery and a history snapshot that is carried down the pipeline to EX for update.

Parameters:
- INDEX_BITS, 8, log2 of table depth; table has 2^INDEX_BITS entries.
- HIST_BITS, 8, global history length; legal range 1..INDEX_BITS.
- CTR_BITS, 2, saturating counter width; legal range 1..4.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- pc_f_i  input  32  fetch PC.
- predict_en_i  input  1  fetch slot holds a branch; the prediction is consumed.
- predict_taken_o  output  1  predicted direction for pc_f_i.
- predict_hist_o  output  HIST_BITS  speculative history used to form the current index; pipelined to EX.
- ready_o  output  1  table initialised; predictions are valid.
- update_en_i  input  1  EX-stage branch resolved.
- update_pc_i  input  32  resolved branch PC.
- update_hist_i  input  HIST_BITS  history snapshot that travelled with the branch.
- update_taken_i  input  1  actual direction.
- update_mispredict_i  input  1  direction was mispredicted; repair history.

Behaviour:
- Reset and initialisation:
  - rst_n is sampled on the clk rising edge only. Low forces state INIT, init_ptr=0, spec_hist=0, ready_o=0.
  - Reset is honoured at any time, including mid-sweep; the sweep restarts at 0.
- State INIT:
  - Writes counter[init_ptr] = 2^(CTR_BITS-1)-1 (weakly not-taken; 0 when CTR_BITS=1).
  - init_ptr increments each cycle; after writing the last entry the state becomes RUN.
  - INIT lasts exactly 2^INDEX_BITS cycles after rst_n is released. ready_o rises on the first RUN cycle.
  - During INIT: predict_taken_o=0, predict_hist_o=0, predict_en_i and update_en_i are ignored, and no history change occurs.
- Index formation:
  - fidx = pc_f_i[INDEX_BITS+1:2] XOR zero-extended spec_hist.
  - uidx = update_pc_i[INDEX_BITS+1:2] XOR zero-extended update_hist_i.
  - History occupies the low HIST_BITS of the index.
- Prediction (RUN):
  - Combinational, zero latency. predict_taken_o = MSB of counter[fidx].
  - predict_hist_o = spec_hist.
- Counter update (RUN, update_en_i=1):
  - counter[uidx] +1 if taken, saturating at 2^CTR_BITS-1; -1 if not taken, saturating at 0.
  - Written at the clock edge.
- History, next-state priority:
  - (1) update_en_i & update_mispredict_i: spec_hist <= {update_hist_i[HIST_BITS-2:0], update_taken_i}. This overrides any same-cycle predict_en_i.
  - (2) otherwise predict_en_i: spec_hist <= {spec_hist[HIST_BITS-2:0], predict_taken_o}.
  - (3) otherwise hold.
  - When HIST_BITS=1 the shift reduces to the new bit only.
  - update_mispredict_i is ignored when update_en_i=0.
- Same-cycle fidx==uidx (no bypass): prediction reads the pre-update counter value.
- Values at ports outside legal parameter ranges are undefined; parameter ranges are checked at elaboration with a fatal error.

Optional Feature:
- GSHARE_FWD_EN defined: when update_en_i=1 in RUN and fidx==uidx in the same cycle, predict_taken_o reflects the MSB of the post-update counter value (write-through forward).
- Undefined: predict_taken_o reflects the stored value, as above.
- History, indexing and init behaviour are identical in both builds.

Test Plan:
- Reset with INDEX_BITS=4: hold rst_n=0 for 2 cycles, release -> ready_o=0 for exactly 16 cycles, then 1. Every entry reads predict_taken_o=0. Pulse rst_n=0 at init cycle 7 -> the sweep restarts and the 16-cycle count restarts.
- CTR_BITS=2, hist=0, PC=0x40: three taken updates -> counter 01->10->11->11 (saturates), predict_taken_o=1. Four not-taken updates -> 11->10->01->00->00, predict_taken_o=0.
- Speculative history, HIST_BITS=4: predict_en_i for 3 cycles with predictions 1,0,1 -> predict_hist_o=4'b0101. Index for PC=0x40 is 0x0 XOR 0x5 = 0x5.
- Recovery: spec_hist=4'b1111, assert update_en_i+update_mispredict_i with update_hist_i=4'b0010, taken=1, and predict_en_i=1 in the same cycle -> next spec_hist=4'b0101 (predict shift dropped).
- Aliasing: PC A=0x10 with hist 0x0 and PC B=0x14 with hist 0x1 both map to index 4. Training A taken twice makes B predict taken.
- Same-cycle read/update on one index with counter=01 and update taken: without GSHARE_FWD_EN predict_taken_o=0 that cycle; with GSHARE_FWD_EN it is 1. Both builds read 1 on the next cycle.
